// File: rtl/hint_queue.sv
// Witness hint queue: decodes raw hints into a DEPTH-entry FIFO for the step consumer.
// Optional HINT_CHECK_EN adds address-alignment checking to the err flag.
module hint_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8+ADDR_W+DATA_W-1:0] raw_hint,
  input  logic                     flush,
  input  logic                     step_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               mask,
  output logic                     is_write,
  output logic [3:0]               syscall_state,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        data,
  output logic [CNT_W-1:0]         hint_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     err
);

  localparam int HINT_W = 8 + ADDR_W + DATA_W;
  localparam int AD_W   = ADDR_W + DATA_W;
  localparam int ENT_W  = 7 + AD_W;
  localparam int PW     = $clog2(DEPTH);

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [PW:0]       r_occ;
  logic [CNT_W-1:0]  r_hint_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_err;

  logic [7:0]        w_meta;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_bad;
  logic              w_push;
  logic              w_pop;
  logic              w_store;
  logic              w_take;
  logic              w_drop;
  logic [ENT_W-1:0]  w_head;

  assign w_meta = raw_hint[HINT_W-1 -: 8];
  assign w_addr = raw_hint[DATA_W +: ADDR_W];
  assign w_data = raw_hint[DATA_W-1:0];

`ifdef HINT_CHECK_EN
  assign w_bad = (w_meta[1:0] == 2'd3)
               | ((w_meta[1:0] == 2'd1) & w_addr[0])
               | ((w_meta[1:0] == 2'd2) & (w_addr[1:0] != 2'd0));
`else
  assign w_bad = (w_meta[1:0] == 2'd3);
`endif

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign in_ready  = !rst && !r_occ[PW];
  assign out_valid = (r_occ != '0);

  assign w_push  = in_valid && in_ready;
  assign w_pop   = out_valid && out_ready;
  assign w_store = w_push && w_meta[7] && !flush;
  assign w_take  = w_pop && !flush;
  assign w_drop  = w_push && !w_meta[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_occ      <= '0;
      r_hint_cnt <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_occ <= '0;
      end else begin
        if (w_store) r_wp <= r_wp + 1'b1;
        if (w_take)  r_rp <= r_rp + 1'b1;
        if (w_store && !w_take)
          r_occ <= r_occ + (PW+1)'(1);
        else if (!w_store && w_take)
          r_occ <= r_occ - (PW+1)'(1);
      end
      // A pop coinciding with step_clear belongs to the new step.
      if (step_clear)
        r_hint_cnt <= CNT_W'(w_take);
      else if (w_take && !(&r_hint_cnt))
        r_hint_cnt <= r_hint_cnt + 1'b1;
      if (w_drop && !(&r_drop_cnt))
        r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_store && w_bad)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store)
      r_mem[r_wp] <= {w_meta[6:0], w_addr, w_data};
  end

  assign w_head        = r_mem[r_rp];
  assign mask          = w_head[AD_W +: 2];
  assign is_write      = w_head[AD_W + 2];
  assign syscall_state = w_head[AD_W + 3 +: 4];
  assign address       = w_head[DATA_W +: ADDR_W];
  assign data          = w_head[DATA_W-1:0];
  assign hint_count    = r_hint_cnt;
  assign drop_count    = r_drop_cnt;
  assign err           = r_err;

endmodule

// File: tb/tb_hint_queue.sv
// Directed scoreboard bench for hint_queue (default parameters).
// Honours HINT_CHECK_EN for the alignment expectation.
module tb_hint_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] raw_hint;
  logic        flush;
  logic        step_clear;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  mask;
  logic        is_write;
  logic [3:0]  syscall_state;
  logic [31:0] address;
  logic [31:0] data;
  logic [7:0]  hint_count;
  logic [7:0]  drop_count;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] sb[$];
  int          e_hc;
  int          e_dc;
  logic        e_err;

  hint_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .raw_hint(raw_hint), .flush(flush), .step_clear(step_clear),
    .out_valid(out_valid), .out_ready(out_ready), .mask(mask),
    .is_write(is_write), .syscall_state(syscall_state),
    .address(address), .data(data), .hint_count(hint_count),
    .drop_count(drop_count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mk(
    input logic [7:0] m, input logic [31:0] a, input logic [31:0] d);
    return {m, a, d};
  endfunction

  function automatic logic bad(input logic [71:0] h);
    logic [1:0]  mk_m;
    logic [31:0] ad;
    mk_m = h[65:64];
    ad   = h[63:32];
    bad  = (mk_m == 2'd3);
`ifdef HINT_CHECK_EN
    bad = bad || (mk_m == 2'd1 && ad[0])
              || (mk_m == 2'd2 && ad[1:0] != 2'd0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(sb.size() < 4));
    chk({tag, ".hint_count"}, 64'(hint_count), 64'(e_hc));
    chk({tag, ".drop_count"}, 64'(drop_count), 64'(e_dc));
    chk({tag, ".err"}, 64'(err), 64'(e_err));
  endtask

  // One clock: inputs applied at a negedge, effects checked at the next.
  task automatic step(input string tag, input logic iv,
                      input logic [71:0] h, input logic ordy,
                      input logic fl, input logic sc);
    logic        take;
    logic        push;
    logic [71:0] e;
    in_valid   = iv;
    raw_hint   = h;
    out_ready  = ordy;
    flush      = fl;
    step_clear = sc;
    take = !fl && out_valid && ordy;
    push = iv && in_ready;
    if (take) begin
      if (sb.size() == 0) begin
        chk({tag, ".pop_underflow"}, 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk({tag, ".mask"}, 64'(mask), 64'(e[65:64]));
        chk({tag, ".is_write"}, 64'(is_write), 64'(e[66]));
        chk({tag, ".syscall"}, 64'(syscall_state), 64'(e[70:67]));
        chk({tag, ".address"}, 64'(address), 64'(e[63:32]));
        chk({tag, ".data"}, 64'(data), 64'(e[31:0]));
      end
    end
    if (sc) e_hc = take ? 1 : 0;
    else if (take && e_hc < 255) e_hc++;
    if (push && !h[71] && e_dc < 255) e_dc++;
    if (fl) sb.delete();
    else if (push && h[71]) begin
      sb.push_back(h);
      if (bad(h)) e_err = 1'b1;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    step_clear = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    e_hc  = 0;
    e_dc  = 0;
    e_err = 1'b0;
    chk("rst.in_ready_low", 64'(in_ready), 64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.counts", 64'({hint_count, drop_count}), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst.in_ready_after", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [71:0] h;
    in_valid   = 1'b0;
    raw_hint   = '0;
    flush      = 1'b0;
    step_clear = 1'b0;
    out_ready  = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    do_reset();

    // Basic decode and pop.
    step("basic_push", 1'b1, mk(8'h85, 32'h1000, 32'hDEAD_BEEF),
         1'b0, 1'b0, 1'b0);
    chk("basic.mask", 64'(mask), 64'(1));
    chk("basic.addr", 64'(address), 64'h1000);
    chk("basic.data", 64'(data), 64'hDEAD_BEEF);
    step("basic_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("basic.hint_count", 64'(hint_count), 64'(1));

    // Fill to full, hold off the fifth, then drain across the wrap.
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, mk(8'h80 | 8'(i << 3), 32'h2000 + 32'(4 * i),
           32'hA000 + 32'(i)), 1'b0, 1'b0, 1'b0);
    chk("full.in_ready", 64'(in_ready), 64'(0));
    step("full_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("fifth", 1'b1, mk(8'h82, 32'h3000, 32'hA004),
         1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain.empty", 64'(out_valid), 64'(0));

    // valid=0 hint is dropped.
    step("drop", 1'b1, mk(8'h05, 32'h10, 32'h20), 1'b0, 1'b0, 1'b0);
    chk("drop.count", 64'(drop_count), 64'(1));

    // Streaming until hint_count saturates.
    for (int i = 0; i < 300; i++)
      step("stream", 1'b1, mk(8'h80 | 8'($urandom_range(0, 127) & 8'h7E),
           $urandom & 32'hFFFF_FFFC, $urandom), 1'b1, 1'b0, 1'b0);
    chk("sat.hint_count", 64'(hint_count), 64'(255));
    step("clear_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("clear.hint_count", 64'(hint_count), 64'(1));
    step("clear_only", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Flush beats simultaneous push and pop.
    for (int i = 0; i < 3; i++)
      step("pre_flush", 1'b1, mk(8'h81, 32'h4000 + 32'(2 * i), 32'(i)),
           1'b0, 1'b0, 1'b0);
    step("flush_push", 1'b1, mk(8'h83, 32'h5000, 32'h55),
         1'b1, 1'b1, 1'b0);
    chk("flush.out_valid", 64'(out_valid), 64'(0));
    step("flush_drop", 1'b1, mk(8'h00, 32'h0, 32'h0),
         1'b0, 1'b1, 1'b0);
    step("post_flush", 1'b1, mk(8'h90, 32'h6000, 32'h66),
         1'b0, 1'b0, 1'b0);
    step("post_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Sticky err on mask=3, cleared by reset.
    step("err_push", 1'b1, mk(8'h83, 32'h7000, 32'h77),
         1'b0, 1'b0, 1'b0);
    chk("err.set", 64'(err), 64'(1));
    step("err_hold", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("err_hold2", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    do_reset();

    // Misaligned word access.
    h = mk(8'h82, 32'h1002, 32'h12);
    step("misalign", 1'b1, h, 1'b0, 1'b0, 1'b0);
`ifdef HINT_CHECK_EN
    chk("misalign.err", 64'(err), 64'(1));
`else
    chk("misalign.err", 64'(err), 64'(0));
`endif
    step("misalign_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hint_queue.md
# hint_queue

Buffered, parametrised successor of the single-hint decoder in the tiny86 circuit. It accepts raw witness hints over a ready/valid stream and splits each into meta, address and data fields. Valid hints are held in a DEPTH-entry FIFO and presented, already decoded, to the step consumer over a second ready/valid stream. It also counts consumed hints per step, drops hints whose valid bit is clear, and flags malformed hints.

## Interface
Parameters:
- ADDR_W, 32, address field width
- DATA_W, 32, data field width
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, width of per-step consumed-hint counter

Raw hint layout, HINT_W = 8+ADDR_W+DATA_W:
- data in [DATA_W-1:0]
- address above data
- meta byte in the top 8 bits: [1:0] mask, [2] is_write, [6:3] syscall_state, [7] valid

Ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  raw hint offered
- in_ready  out  1  block can accept a hint
- raw_hint  in  HINT_W  raw hint word
- flush  in  1  discard all queued hints
- step_clear  in  1  zero the consumed-hint counter
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head entry
- mask  out  2  head access size: 0=1B, 1=2B, 2=4B, 3=illegal
- is_write  out  1  head is a write
- syscall_state  out  4  head syscall state
- address  out  ADDR_W  head address
- data  out  DATA_W  head data
- hint_count  out  CNT_W  hints popped since last step_clear/reset
- drop_count  out  CNT_W  valid=0 hints discarded since reset
- err  out  1  sticky malformed-hint flag

## Operation
Handshakes:
- Push when in_valid && in_ready.
- Pop when out_valid && out_ready.
- in_ready = !rst && occupancy < DEPTH. out_valid = occupancy != 0.
- Pushed hint with meta[7]=1: decoded fields written at the write pointer; occupancy +1.
- Pushed hint with meta[7]=0: accepted, not stored; drop_count +1, saturating at 2^CNT_W-1.
- Simultaneous push and pop: occupancy unchanged; both pointers advance. Cannot occur when full, because in_ready is low.
- No empty bypass: a pushed hint is never visible at the output in its push cycle.

Pointers and outputs:
- Pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy is log2(DEPTH)+1 bits.
- Output fields are driven from the entry at the read pointer.
- Output fields are don't-care when out_valid=0; the bench must not check them.

Counters and errors:
- hint_count +1 per pop, saturating.
- step_clear zeroes hint_count. If step_clear and a pop coincide, the result is 1: the pop is counted in the new step.
- err is set on a push with valid=1 and mask=3. It is cleared only by rst. Such hints are still enqueued.

flush:
- Zeroes occupancy and both pointers next cycle.
- Has priority over a same-cycle push or pop. A hint offered then is lost; counters ignore both.
- A dropped valid=0 hint offered in the flush cycle is still counted.
- hint_count, drop_count and err are unaffected.

Reset, synchronous (rst has priority over flush/step_clear):
- occupancy, pointers, hint_count and drop_count = 0.
- err = 0, out_valid = 0.
- in_ready = 0 while rst is high and 1 in the first cycle after.

## Timing
- Push at cycle N yields out_valid=1 with the decoded fields at N+1.
- Sustained throughput is 1 hint/cycle in and out.
- DEPTH back-to-back pushes with no pops give in_ready=0 from the cycle after the DEPTH-th push.
- in_ready rises the cycle after the first pop from full.
- hint_count, drop_count and err update the cycle after the triggering handshake.
- in_ready and out_valid depend only on registered state; no combinational in-to-out paths.

## Configuration
HINT_CHECK_EN:
- Defined: a push with valid=1 also sets err if the address is misaligned for its size.
  - mask=1 with address[0]≠0.
  - mask=2 with address[1:0]≠0.
  - Misaligned hints are still enqueued.
- Undefined: only the mask=3 rule sets err; the alignment logic is absent.

## Test plan
- Reset, then push {meta=8'h85, address=32'h1000, data=32'hDEAD_BEEF} → next cycle out_valid=1, mask=1, is_write=1, syscall_state=0, address=32'h1000, data=32'hDEADBEEF; pop → hint_count=1.
- DEPTH=4: push 5 consecutive hints with out_ready=0 → in_ready=0 after the 4th push; 5th held off; pop one → 5th accepted; output order matches push order across pointer wrap.
- Push meta=8'h05 (valid=0) → out_valid stays 0, drop_count=1, hint_count=0.
- Continuous push+pop for 300 cycles with CNT_W=8 → hint_count saturates at 255; step_clear with a same-cycle pop → hint_count=1.
- Fill 3 entries, assert flush with a simultaneous push → out_valid=0 next cycle, new hint not stored, counters unchanged.
- Push mask=3 → err=1 and stays until rst. With HINT_CHECK_EN, push mask=2 at address 32'h1002 → err=1; without the macro → err=0.
